// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the digit-serial subtractor.
interface serial_subtractor_if #(
    parameter int WIDTH = 32
);
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_diff;
    logic             o_borrow;
    logic             o_ovf;

    modport slave (
        input  i_valid, i_a, i_b, i_ready,
        output o_ready, o_valid, o_diff, o_borrow, o_ovf
    );

    modport master (
        output i_valid, i_a, i_b, i_ready,
        input  o_ready, o_valid, o_diff, o_borrow, o_ovf
    );
endinterface

// File: rtl/serial_subtractor.sv
// Digit-serial a - b (as a + ~b + 1) reusing one DIGIT-bit adder slice over WIDTH/DIGIT cycles.
// state  | meaning
// S_IDLE | ready for operands, last result retained
// S_BUSY | one digit summed per cycle, carry kept in a flop
// S_DONE | result valid, held until downstream accepts
module serial_subtractor #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input logic           i_clk,
    input logic           i_rst_n,
    serial_subtractor_if.slave bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             carry_q, carry_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q, ovf_d;
    logic             amsb_q, amsb_d;
    logic             bmsb_q, bmsb_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [DIGIT:0]   slice;
    logic [WIDTH-1:0] res_shift;

    assign slice = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
                 + (DIGIT+1)'(carry_q);
    // New digit enters at the top so digit 0 lands at the bottom after N shifts.
    assign res_shift = (res_q >> DIGIT) | (WIDTH'(slice[DIGIT-1:0]) << (WIDTH - DIGIT));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            amsb_q   <= 1'b0;
            bmsb_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
            amsb_q   <= amsb_d;
            bmsb_q   <= bmsb_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        diff_d   = diff_q;
        carry_d  = carry_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        amsb_d   = amsb_q;
        bmsb_d   = bmsb_q;
        cnt_d    = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (bus.i_valid) begin
                    a_d     = bus.i_a;
                    b_d     = ~bus.i_b;
                    res_d   = '0;
                    carry_d = 1'b1;
                    cnt_d   = '0;
                    amsb_d  = bus.i_a[WIDTH-1];
                    bmsb_d  = bus.i_b[WIDTH-1];
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                res_d   = res_shift;
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = slice[DIGIT];
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    diff_d   = res_shift;
                    borrow_d = ~slice[DIGIT];
                    ovf_d    = (amsb_q != bmsb_q) && (res_shift[WIDTH-1] != amsb_q);
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.i_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.o_ready  = (state_q == S_IDLE);
    assign bus.o_valid  = (state_q == S_DONE);
    assign bus.o_diff   = diff_q;
    assign bus.o_borrow = borrow_q;
    assign bus.o_ovf    = ovf_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized checks of serial_subtractor at DIGIT = 4, 1, 8 and 32 driven in lockstep.
module tb_serial_subtractor;
    localparam int W = 32;

    logic clk;
    logic rst_n;
    logic valid;
    logic rdy;
    logic [W-1:0] a;
    logic [W-1:0] b;

    int n_chk = 0;
    int n_err = 0;

    serial_subtractor_if #(.WIDTH(W)) b4 ();
    serial_subtractor_if #(.WIDTH(W)) b1 ();
    serial_subtractor_if #(.WIDTH(W)) b8 ();
    serial_subtractor_if #(.WIDTH(W)) b32 ();

    serial_subtractor #(.WIDTH(W), .DIGIT(4))  u_d4  (.i_clk(clk), .i_rst_n(rst_n), .bus(b4));
    serial_subtractor #(.WIDTH(W), .DIGIT(1))  u_d1  (.i_clk(clk), .i_rst_n(rst_n), .bus(b1));
    serial_subtractor #(.WIDTH(W), .DIGIT(8))  u_d8  (.i_clk(clk), .i_rst_n(rst_n), .bus(b8));
    serial_subtractor #(.WIDTH(W), .DIGIT(32)) u_d32 (.i_clk(clk), .i_rst_n(rst_n), .bus(b32));

    assign b4.i_valid  = valid;
    assign b4.i_a      = a;
    assign b4.i_b      = b;
    assign b4.i_ready  = rdy;
    assign b1.i_valid  = valid;
    assign b1.i_a      = a;
    assign b1.i_b      = b;
    assign b1.i_ready  = rdy;
    assign b8.i_valid  = valid;
    assign b8.i_a      = a;
    assign b8.i_b      = b;
    assign b8.i_ready  = rdy;
    assign b32.i_valid = valid;
    assign b32.i_a     = a;
    assign b32.i_b     = b;
    assign b32.i_ready = rdy;

    logic [W-1:0] dif_a [4];
    logic         vld_a [4];
    logic         rdo_a [4];
    logic         brw_a [4];
    logic         ovf_a [4];
    int           exp_lat [4] = '{8, 32, 4, 1};

    assign dif_a[0] = b4.o_diff;   assign dif_a[1] = b1.o_diff;
    assign dif_a[2] = b8.o_diff;   assign dif_a[3] = b32.o_diff;
    assign vld_a[0] = b4.o_valid;  assign vld_a[1] = b1.o_valid;
    assign vld_a[2] = b8.o_valid;  assign vld_a[3] = b32.o_valid;
    assign rdo_a[0] = b4.o_ready;  assign rdo_a[1] = b1.o_ready;
    assign rdo_a[2] = b8.o_ready;  assign rdo_a[3] = b32.o_ready;
    assign brw_a[0] = b4.o_borrow; assign brw_a[1] = b1.o_borrow;
    assign brw_a[2] = b8.o_borrow; assign brw_a[3] = b32.o_borrow;
    assign ovf_a[0] = b4.o_ovf;    assign ovf_a[1] = b1.o_ovf;
    assign ovf_a[2] = b8.o_ovf;    assign ovf_a[3] = b32.o_ovf;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_ready();
        return 32'(rdo_a[0] & rdo_a[1] & rdo_a[2] & rdo_a[3]);
    endfunction

    // Issue one operation to all four instances; rnd selects random output backpressure.
    task automatic op(input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic [W-1:0] ed, input logic eb, input logic eo,
                      input bit rnd, input int gap, input int hold);
        int  lat [4];
        bit  seen [4];
        bit  done [4];
        int  k;
        bit  all_seen;
        bit  all_done;
        repeat (gap) @(negedge clk);
        k = 0;
        while (all_ready() != 32'd1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("idle_wait", all_ready(), 32'd1);
        valid = 1'b1;
        a = av;
        b = bv;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        a = $urandom;
        b = $urandom;
        for (int i = 0; i < 4; i++) begin
            seen[i] = 1'b0;
            done[i] = 1'b0;
            lat[i]  = 0;
        end
        k = 0;
        all_done = 1'b0;
        while (!all_done && k < 400) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            for (int i = 0; i < 4; i++)
                if (!seen[i] && vld_a[i]) begin
                    seen[i] = 1'b1;
                    lat[i]  = k;
                end
            all_seen = seen[0] & seen[1] & seen[2] & seen[3];
            if (all_seen && hold > 0) begin
                for (int h = 1; h <= hold; h++) begin
                    if (h == 2) begin
                        valid = 1'b1;
                        a = ~av;
                        b = av ^ bv;
                    end
                    @(posedge clk);
                    @(negedge clk);
                    valid = 1'b0;
                    for (int i = 0; i < 4; i++) begin
                        chk("bp_valid", 32'(vld_a[i]), 32'd1);
                        chk("bp_ready", 32'(rdo_a[i]), 32'd0);
                        chk("bp_diff", dif_a[i], ed);
                        chk("bp_flags", {30'd0, brw_a[i], ovf_a[i]}, {30'd0, eb, eo});
                    end
                end
                hold = 0;
            end
            rdy = rnd ? 1'($urandom_range(0, 1)) : all_seen;
            for (int i = 0; i < 4; i++)
                if (seen[i] && !done[i] && rdy) begin
                    chk("latency", 32'(lat[i]), 32'(exp_lat[i]));
                    chk("diff", dif_a[i], ed);
                    chk("borrow", 32'(brw_a[i]), 32'(eb));
                    chk("ovf", 32'(ovf_a[i]), 32'(eo));
                    done[i] = 1'b1;
                end
            all_done = done[0] & done[1] & done[2] & done[3];
        end
        if (!all_done) chk("op_timeout", 32'd0, 32'd1);
        @(posedge clk);
        @(negedge clk);
        rdy = 1'b0;
        chk("post_xfer_valid", 32'(b4.o_valid), 32'd0);
        chk("post_xfer_ready", 32'(b4.o_ready), 32'd1);
    endtask

    logic [W-1:0] av, bv;
    logic [W:0]   ud, sd;

    initial begin
        rst_n = 1'b0;
        valid = 1'b0;
        rdy   = 1'b0;
        a     = '0;
        b     = '0;
        #1;
        chk("rst_diff", b4.o_diff, 32'd0);
        chk("rst_flags", {30'd0, b4.o_borrow, b4.o_ovf}, 32'd0);
        chk("rst_valid", 32'(b4.o_valid), 32'd0);
        chk("rst_ready", 32'(b4.o_ready), 32'd1);
        #20;
        @(negedge clk);
        rst_n = 1'b1;

        op(32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 0, 0);
        op(32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1, 0);
        op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 0, 0);
        op(32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 2, 0);
        op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b1, 1'b0, 0, 5);

        // Abort in the 4th BUSY cycle of the DIGIT=4 instance.
        @(negedge clk);
        valid = 1'b1;
        a = 32'h0000_1234;
        b = 32'h0000_0001;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("pre_rst_busy", 32'(b4.o_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_diff", b4.o_diff, 32'd0);
        chk("async_rst_flags", {30'd0, b4.o_borrow, b4.o_ovf}, 32'd0);
        chk("async_rst_valid", 32'(b4.o_valid), 32'd0);
        chk("async_rst_ready", 32'(b4.o_ready), 32'd1);
        chk("async_rst_d32_valid", 32'(b32.o_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        op(32'h0000_0010, 32'h0000_0001, 32'h0000_000F, 1'b0, 1'b0, 1'b0, 0, 0);

        for (int t = 0; t < 1000; t++) begin
            av = $urandom;
            bv = $urandom;
            if (t % 8 == 0) bv = av;
            if (t % 8 == 1) av = '0;
            if (t % 8 == 2) bv = {1'b1, bv[W-2:0]};
            ud = {1'b0, av} - {1'b0, bv};
            sd = {av[W-1], av} - {bv[W-1], bv};
            op(av, bv, ud[W-1:0], ud[W], sd[W] ^ sd[W-1], 1'b1, $urandom_range(0, 3), 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Digit-serial 32-bit subtractor computing `i_a - i_b` over `WIDTH/DIGIT` clock cycles, with a valid/ready handshake on both input and output. It is the inverse-operation companion to the combinational ripple adders in the adder suite. It lets area/timing comparisons include a multi-cycle datapath that reuses one `DIGIT`-bit adder slice. Subtraction is formed as `a + ~b + 1`, with the carry held in a flop between digits.

## Interface
- `WIDTH`, 32, operand and result width in bits.
- `DIGIT`, 4, bits processed per cycle. It must divide `WIDTH`; legal values are 1 to `WIDTH`.
- `i_clk`  input  1  clock; all state updates on the rising edge.
- `i_rst_n`  input  1  reset, asynchronous, active-low.
- `i_valid`  input  1  operands on `i_a`/`i_b` are valid.
- `o_ready`  output  1  block can accept operands.
- `i_a`  input  WIDTH  minuend.
- `i_b`  input  WIDTH  subtrahend.
- `o_valid`  output  1  result outputs are valid.
- `i_ready`  input  1  downstream accepts the result.
- `o_diff`  output  WIDTH  `(i_a - i_b) mod 2^WIDTH`.
- `o_borrow`  output  1  unsigned borrow: 1 iff `a < b` unsigned.
- `o_ovf`  output  1  signed two's-complement overflow.

## Operation
- **FSM states:** IDLE, BUSY, DONE. Define N = `WIDTH/DIGIT`.
- **IDLE:**
  - `o_ready` = 1, `o_valid` = 0.
  - On `i_valid && o_ready`: latch `i_a` into the A shift register and `~i_b` into the B shift register.
  - Also: clear the result register, set carry = 1, clear the digit counter, go to BUSY.
- **BUSY:**
  - Each cycle: `{c, s} = A[DIGIT-1:0] + B[DIGIT-1:0] + carry`.
  - `s` shifts into the result register MSB-side, so digit 0 ends at bits `[DIGIT-1:0]`. A and B shift right by `DIGIT`, and carry ← `c`.
  - The counter increments. On the Nth digit (counter = N-1), go to DONE.
  - `o_ready` = 0, `o_valid` = 0.
- **DONE:**
  - `o_valid` = 1. `o_diff`, `o_borrow` and `o_ovf` are held stable.
  - On `i_ready`: go to IDLE.
- **Flags:**
  - `o_borrow` = ~(final carry).
  - `o_ovf` = `(a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1])`. Capture the a/b MSBs at acceptance.
- **Input acceptance:**
  - `i_valid` is ignored outside IDLE.
  - Operands are sampled only on the acceptance edge; later changes on `i_a`/`i_b` have no effect.
- **Counter:** width is `$clog2(N)`, minimum 1 bit. For `DIGIT` = `WIDTH`, BUSY lasts exactly one cycle.

## Timing
- **Reset (asynchronous, `i_rst_n` low):**
  - State = IDLE; all registers are cleared, including carry and the counter.
  - Outputs during and after reset: `o_diff` = 0, `o_borrow` = 0, `o_ovf` = 0, `o_valid` = 0, `o_ready` = 1.
  - Reset in any state, including mid-BUSY or DONE, aborts the operation with no partial result exposed.
- **Control outputs:** `o_ready` and `o_valid` are decoded from registered state only, with no combinational path from `i_valid`/`i_ready`.
- **Latency:**
  - Acceptance at edge E0; BUSY spans edges E1..EN.
  - `o_valid` rises after edge EN: N cycles after acceptance, 8 for the default parameters.
- **Output handshake:**
  - Transfer occurs at the edge where `o_valid && i_ready`; `o_valid` falls and `o_ready` rises after that edge.
  - With `i_ready` held high, throughput is one operation per N+2 cycles.
  - Backpressure is unbounded: DONE holds indefinitely with outputs constant.
- **Output stability:** `o_diff` and the flags change only on transitions into DONE (or on reset). They retain the last result in IDLE and BUSY, but are meaningful only while `o_valid` = 1.

## Test plan
Default parameters (`WIDTH` = 32, `DIGIT` = 4) unless noted.
- **Basic:** accept `a=0x0000_0005`, `b=0x0000_0003` → `o_valid` exactly 8 cycles after acceptance; `o_diff=0x0000_0002`, `o_borrow=0`, `o_ovf=0`.
- **Full borrow chain:** `0x0000_0000 - 0x0000_0001` → `o_diff=0xFFFF_FFFF`, `o_borrow=1`, `o_ovf=0`. Also `0xFFFF_FFFF - 0xFFFF_FFFF` → `0x0000_0000`, `o_borrow=0`.
- **Signed overflow:**
  - `0x8000_0000 - 0x0000_0001` → `0x7FFF_FFFF`, `o_ovf=1`, `o_borrow=0`.
  - `0x7FFF_FFFF - 0xFFFF_FFFF` → `0x8000_0000`, `o_ovf=1`, `o_borrow=1`.
- **Backpressure:**
  - Hold `i_ready=0` for 5 cycles in DONE: outputs constant, `o_ready=0`.
  - A pulse of `i_valid` with new operands during that window is ignored.
  - After `i_ready=1`, `o_ready=1` on the next cycle.
- **Reset mid-operation:**
  - Assert `i_rst_n=0` asynchronously during the 4th BUSY cycle: all outputs go to reset values immediately, without waiting for a clock edge, and `o_ready=1`.
  - After release, `0x10 - 0x01` → `0x0F` with correct latency.
- **Randomized:**
  - 1000 random operand pairs with random `i_valid`/`i_ready` gaps, checked against golden `a-b`, the borrow and the overflow flags.
  - Repeat for `DIGIT=1` (latency 32), `DIGIT=8` (latency 4) and `DIGIT=32` (latency 1).
